amo_seq: RTL and testbench

//  LSU-side atomic sequencer: owns the data-bus read/modify/write sequence for A-extension ops and feeds the amo unit.

---
 rtl/a_ext_pkg.sv | 39 +++
 rtl/amo_seq_if.sv | 53 +++++
 rtl/amo_resv.sv | 48 ++++
 rtl/amo_seq.sv | 186 ++++++++++++++++++
 tb/tb_amo_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/a_ext_pkg.sv
// Shared A-extension types: AMO opcodes (also used by the amo unit), sequencer states, SC result codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package a_ext_pkg;

   // Encodings follow the RISC-V funct5 field of the AMO instruction.
   typedef enum logic [4:0] {
      AMO_ADD  = 5'b00000,
      AMO_SWAP = 5'b00001,
      AMO_LR   = 5'b00010,
      AMO_SC   = 5'b00011,
      AMO_XOR  = 5'b00100,
      AMO_OR   = 5'b01000,
      AMO_AND  = 5'b01100,
      AMO_MIN  = 5'b10000,
      AMO_MAX  = 5'b10100,
      AMO_MINU = 5'b11000,
      AMO_MAXU = 5'b11100
   } type_amo_ops_e;

   typedef enum logic [2:0] {
      SEQ_IDLE  = 3'd0,
      SEQ_CHECK = 3'd1,
      SEQ_RD    = 3'd2,
      SEQ_CALC  = 3'd3,
      SEQ_WR    = 3'd4,
      SEQ_RESP  = 3'd5
   } type_amo_seq_state_e;

   // Value returned in rd by a store-conditional.
   localparam int AMO_SC_PASS = 0;
   localparam int AMO_SC_FAIL = 1;

   // Word ops only: the two address LSBs must be clear.
   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return lsb == 2'b00;
   endfunction

endpackage

// File: rtl/amo_seq_if.sv
// LSU request/response, data-bus and amo-unit signals of the atomic sequencer.
// Latency: n/a (wiring only).
// Backpressure: bus_req_o held until bus_ack_i; amo unit answers amo_req_o with amo_valid_i.
interface amo_seq_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // LSU side
   logic              req_i;
   logic [4:0]        op_i;
   logic [ADDR_W-1:0] addr_i;
   logic [DATA_W-1:0] rs2_i;
   logic              snoop_st_i;
   logic [ADDR_W-1:0] snoop_addr_i;
   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic [DATA_W-1:0] rd_data_o;
   // data bus
   logic              bus_req_o;
   logic              bus_we_o;
   logic [ADDR_W-1:0] bus_addr_o;
   logic [DATA_W-1:0] bus_wdata_o;
   logic              bus_ack_i;
   logic [DATA_W-1:0] bus_rdata_i;
   // amo unit
   logic              amo_req_o;
   logic [4:0]        amo_op_o;
   logic [DATA_W-1:0] amo_rdata_o;
   logic [DATA_W-1:0] amo_rs2_o;
   logic              amo_valid_i;
   logic [DATA_W-1:0] amo_result_i;

   // master: the sequencer itself
   modport master (
      input  req_i, op_i, addr_i, rs2_i, snoop_st_i, snoop_addr_i,
      output busy_o, done_o, err_o, rd_data_o,
      output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
      input  bus_ack_i, bus_rdata_i,
      output amo_req_o, amo_op_o, amo_rdata_o, amo_rs2_o,
      input  amo_valid_i, amo_result_i
   );

   // slave: LSU, memory and amo unit surrounding the sequencer
   modport slave (
      output req_i, op_i, addr_i, rs2_i, snoop_st_i, snoop_addr_i,
      input  busy_o, done_o, err_o, rd_data_o,
      input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
      output bus_ack_i, bus_rdata_i,
      input  amo_req_o, amo_op_o, amo_rdata_o, amo_rs2_o,
      output amo_valid_i, amo_result_i
   );
endinterface

// File: rtl/amo_resv.sv
// LR/SC reservation: one valid bit plus word address, set by LR, cleared by SC/error/matching snoop.
// Latency: set/clear visible on hit_o the cycle after the request.
// Backpressure: none; a snoop in the same cycle as a set wins (reservation ends invalid).
module amo_resv #(
   parameter int WA = 30
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_i,
   input  logic [WA-1:0] set_addr_i,
   input  logic          clr_i,
   input  logic          snoop_st_i,
   input  logic [WA-1:0] snoop_addr_i,
   input  logic [WA-1:0] chk_addr_i,
   output logic          hit_o
);
   logic          vld_q, vld_d;
   logic [WA-1:0] addr_q, addr_d;

   // Next reservation: set first, then clear/snoop override so clear always wins.
   always_comb begin
      vld_d  = vld_q;
      addr_d = addr_q;
      if (set_i) begin
         vld_d  = 1'b1;
         addr_d = set_addr_i;
      end
      if (clr_i) begin
         vld_d = 1'b0;
      end
      if (snoop_st_i && (snoop_addr_i == addr_d)) begin
         vld_d = 1'b0;
      end
   end

   // Reservation register; reset leaves it invalid.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         vld_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         vld_q  <= vld_d;
         addr_q <= addr_d;
      end
   end

   assign hit_o = vld_q && (chk_addr_i == addr_q);
endmodule

// File: rtl/amo_seq.sv
// Atomic sequencer: runs read / amo-unit / write-back on the data bus for one LR, SC or AMO at a time.
// Latency: AMO 5 cycles req->done with zero-wait bus and amo unit; LR 3; SC fail or misaligned 2.
// Backpressure: req_i ignored while busy_o; waits on bus_ack_i/amo_valid_i (bounded when AMO_SEQ_TIMEOUT_EN is defined).
module amo_seq
   import a_ext_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input logic       clk,
   input logic       rst_n,   // active-high synchronous reset
   amo_seq_if.master io
);
   localparam int WA = ADDR_W - 2;

   type_amo_seq_state_e state_q, state_d;
   type_amo_ops_e       op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rs2_q, rs2_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rd_q, rd_d;
   logic                err_q, err_d;
   logic                amo_first_q, amo_first_d;
   logic                misaligned;
   logic                resv_hit;
   logic                resv_set;
   logic                resv_clr;
   logic                timeout;
   logic                unused_snoop_lsb;

   assign misaligned       = !is_word_aligned(addr_q[1:0]);
   assign unused_snoop_lsb = ^io.snoop_addr_i[1:0];

`ifdef AMO_SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            waiting;

   assign waiting = (((state_q == SEQ_RD) || (state_q == SEQ_WR)) && !io.bus_ack_i) ||
                    ((state_q == SEQ_CALC) && !io.amo_valid_i);
   assign timeout = waiting && (wd_q == WD_W'(TIMEOUT_CYC - 1));

   // Watchdog counts cycles spent in a waiting state; restarts on every state entry.
   always_comb begin
      wd_d = '0;
      if ((state_d == state_q) &&
          ((state_q == SEQ_RD) || (state_q == SEQ_CALC) || (state_q == SEQ_WR))) begin
         wd_d = wd_q + 1'b1;
      end
   end

   // Watchdog register.
   always_ff @(posedge clk) begin
      if (rst_n) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst_n) state_q <= SEQ_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; an expired watchdog overrides any wait.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SEQ_IDLE:  if (io.req_i) state_d = SEQ_CHECK;
         SEQ_CHECK: begin
            if (misaligned)          state_d = SEQ_RESP;
            else if (op_q == AMO_SC) state_d = resv_hit ? SEQ_WR : SEQ_RESP;
            else                     state_d = SEQ_RD;
         end
         SEQ_RD:    if (io.bus_ack_i) state_d = (op_q == AMO_LR) ? SEQ_RESP : SEQ_CALC;
         SEQ_CALC:  if (io.amo_valid_i) state_d = SEQ_WR;
         SEQ_WR:    if (io.bus_ack_i) state_d = SEQ_RESP;
         SEQ_RESP:  state_d = SEQ_IDLE;
         default:   state_d = SEQ_IDLE;
      endcase
      if (timeout) state_d = SEQ_RESP;
   end

   // Transaction datapath: latch request, read data, amo result and the rd value.
   always_comb begin
      op_d        = op_q;
      addr_d      = addr_q;
      rs2_d       = rs2_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      err_d       = err_q;
      unique case (state_q)
         SEQ_IDLE: begin
            if (io.req_i) begin
               op_d   = type_amo_ops_e'(io.op_i);
               addr_d = io.addr_i;
               rs2_d  = io.rs2_i;
               rd_d   = '0;
               err_d  = 1'b0;
            end
         end
         SEQ_CHECK: begin
            if (misaligned) begin
               err_d = 1'b1;
            end else if (op_q == AMO_SC) begin
               wdata_d = rs2_q;
               rd_d    = resv_hit ? DATA_W'(AMO_SC_PASS) : DATA_W'(AMO_SC_FAIL);
            end
         end
         SEQ_RD: begin
            if (io.bus_ack_i) begin
               rdata_d = io.bus_rdata_i;
               rd_d    = io.bus_rdata_i;
            end
         end
         SEQ_CALC: if (io.amo_valid_i) wdata_d = io.amo_result_i;
         default: ;
      endcase
      if (timeout) begin
         err_d = 1'b1;
         rd_d  = '0;
      end
      amo_first_d = (state_d == SEQ_CALC) && (state_q != SEQ_CALC);
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         op_q        <= AMO_ADD;
         addr_q      <= '0;
         rs2_q       <= '0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         err_q       <= 1'b0;
         amo_first_q <= 1'b0;
      end else begin
         op_q        <= op_d;
         addr_q      <= addr_d;
         rs2_q       <= rs2_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
         amo_first_q <= amo_first_d;
      end
   end

   // Reservation is taken on the LR read ack and dropped when an SC or an errored op completes.
   assign resv_set = (state_q == SEQ_RD) && io.bus_ack_i && (op_q == AMO_LR);
   assign resv_clr = (state_q == SEQ_RESP) && ((op_q == AMO_SC) || err_q);

   amo_resv #(.WA(WA)) u_resv (
      .clk          (clk),
      .rst_n        (rst_n),
      .set_i        (resv_set),
      .set_addr_i   (addr_q[ADDR_W-1:2]),
      .clr_i        (resv_clr),
      .snoop_st_i   (io.snoop_st_i),
      .snoop_addr_i (io.snoop_addr_i[ADDR_W-1:2]),
      .chk_addr_i   (addr_q[ADDR_W-1:2]),
      .hit_o        (resv_hit)
   );

   // Outputs decoded from state and registered datapath; bus fields held while bus_req_o is up.
   always_comb begin
      io.busy_o      = (state_q != SEQ_IDLE) && (state_q != SEQ_RESP);
      io.done_o      = (state_q == SEQ_RESP);
      io.err_o       = (state_q == SEQ_RESP) && err_q;
      io.rd_data_o   = (state_q == SEQ_RESP) ? rd_q : '0;
      io.bus_req_o   = (state_q == SEQ_RD) || (state_q == SEQ_WR);
      io.bus_we_o    = (state_q == SEQ_WR);
      io.bus_addr_o  = io.bus_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      io.bus_wdata_o = (state_q == SEQ_WR) ? wdata_q : '0;
      io.amo_req_o   = amo_first_q;
      io.amo_op_o    = op_q;
      io.amo_rdata_o = rdata_q;
      io.amo_rs2_o   = rs2_q;
   end
endmodule

// File: tb/tb_amo_seq.sv
// Bench for amo_seq: table of single transactions against a word memory and an amo-unit model,
// plus hand sequences for latency, snoop, reset-in-flight and (with AMO_SEQ_TIMEOUT_EN) the watchdog.
// Memory/amo responders are driven #1 after each clock edge so zero-wait answers land in the same cycle.
module tb_amo_seq;
   import a_ext_pkg::*;

   localparam int TO_CYC = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   amo_seq_if #(.ADDR_W(32), .DATA_W(32)) sif ();

   amo_seq #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk   (clk),
      .rst_n (rst),
      .io    (sif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [logic [31:0]];

   // results of the last run_txn
   bit          r_done, r_err, r_busy1, r_busy_done, r_stable;
   logic [31:0] r_rd;
   int          r_lat, r_nrd, r_nwr, r_namo;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] addr;
      logic [31:0] rs2;
      bit          init_en;
      logic [31:0] init_val;
      int          dly;
      int          amo_dly;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_mem;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   function automatic logic [31:0] amo_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         AMO_ADD:  return a + b;
         AMO_SWAP: return b;
         AMO_XOR:  return a ^ b;
         AMO_AND:  return a & b;
         AMO_OR:   return a | b;
         AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
         AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
         AMO_MINU: return (a < b) ? a : b;
         AMO_MAXU: return (a > b) ? a : b;
         default:  return a;
      endcase
   endfunction

   function automatic logic [31:0] outs_or();
      return {23'b0, sif.busy_o, sif.done_o, sif.err_o, sif.bus_req_o, sif.bus_we_o, sif.amo_req_o,
              |sif.rd_data_o, |sif.bus_addr_o, |sif.bus_wdata_o | (|sif.amo_rdata_o) | (|sif.amo_rs2_o) | (|sif.amo_op_o)};
   endfunction

   // One transaction; snoop_mode 1 = matching store on the read ack, 2 = on the write ack.
   task automatic run_txn(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                          input int rd_dly, input int wr_dly, input int amo_dly,
                          input int snoop_mode, input int max_cyc);
      int          wait_cnt, amo_cnt;
      bit          amo_pend, p_req, p_ack, p_we;
      logic [31:0] amo_a, amo_b, p_addr, p_wdata;
      logic [4:0]  amo_o;
      r_done = 0; r_err = 0; r_rd = 0; r_lat = 0; r_nrd = 0; r_nwr = 0; r_namo = 0;
      r_busy1 = 0; r_busy_done = 0; r_stable = 1;
      wait_cnt = 0; amo_cnt = 0; amo_pend = 0; p_req = 0; p_ack = 0; p_we = 0;
      p_addr = 0; p_wdata = 0; amo_a = 0; amo_b = 0; amo_o = 0;
      @(posedge clk); #1;
      sif.req_i = 1'b1; sif.op_i = op; sif.addr_i = addr; sif.rs2_i = rs2;
      for (int c = 1; c <= max_cyc && !r_done; c++) begin
         @(posedge clk); #1;
         sif.req_i = 1'b0; sif.bus_ack_i = 1'b0; sif.amo_valid_i = 1'b0; sif.snoop_st_i = 1'b0;
         if (c == 1) r_busy1 = sif.busy_o;
         if (p_req && !p_ack && sif.bus_req_o &&
             ((sif.bus_we_o != p_we) || (sif.bus_addr_o != p_addr) || (sif.bus_wdata_o != p_wdata)))
            r_stable = 0;
         p_req = sif.bus_req_o; p_we = sif.bus_we_o; p_addr = sif.bus_addr_o; p_wdata = sif.bus_wdata_o;
         p_ack = 0;
         if (sif.done_o) begin
            r_done = 1; r_lat = c; r_rd = sif.rd_data_o; r_err = sif.err_o; r_busy_done = sif.busy_o;
         end else begin
            if (sif.amo_req_o) begin
               r_namo++; amo_pend = 1; amo_cnt = 0;
               amo_a = sif.amo_rdata_o; amo_b = sif.amo_rs2_o; amo_o = sif.amo_op_o;
            end
            if (amo_pend) begin
               if (amo_cnt == amo_dly) begin
                  sif.amo_valid_i = 1'b1; sif.amo_result_i = amo_model(amo_o, amo_a, amo_b); amo_pend = 0;
               end else amo_cnt++;
            end
            if (sif.bus_req_o) begin
               if (wait_cnt == (sif.bus_we_o ? wr_dly : rd_dly)) begin
                  sif.bus_ack_i = 1'b1; p_ack = 1; wait_cnt = 0;
                  if (sif.bus_we_o) begin
                     mem[sif.bus_addr_o] = sif.bus_wdata_o; r_nwr++;
                     if (snoop_mode == 2) begin sif.snoop_st_i = 1'b1; sif.snoop_addr_i = addr; end
                  end else begin
                     sif.bus_rdata_i = mem_rd(sif.bus_addr_o); r_nrd++;
                     if (snoop_mode == 1) begin sif.snoop_st_i = 1'b1; sif.snoop_addr_i = addr; end
                  end
               end else wait_cnt++;
            end else wait_cnt = 0;
         end
      end
      sif.bus_ack_i = 1'b0; sif.amo_valid_i = 1'b0; sif.snoop_st_i = 1'b0;
   endtask

   task automatic snoop_pulse(input logic [31:0] a);
      @(posedge clk); #1;
      sif.snoop_st_i = 1'b1; sif.snoop_addr_i = a;
      @(posedge clk); #1;
      sif.snoop_st_i = 1'b0;
   endtask

   // Plain transaction with zero waits; result is checked against hand values.
   task automatic txn_chk(input string nm, input logic [4:0] op, input logic [31:0] addr,
                          input logic [31:0] rs2, input int snoop_mode,
                          input logic [31:0] exp_rd, input int exp_nwr);
      run_txn(op, addr, rs2, 0, 0, 0, snoop_mode, 40);
      check({nm, "_done"}, {31'b0, r_done}, 32'd1);
      check({nm, "_rd"}, r_rd, exp_rd);
      check({nm, "_nwr"}, r_nwr, exp_nwr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench did not finish");
   end

   initial begin
      bit quiet;
      sif.req_i = 0; sif.op_i = 0; sif.addr_i = 0; sif.rs2_i = 0;
      sif.snoop_st_i = 0; sif.snoop_addr_i = 0; sif.bus_ack_i = 0; sif.bus_rdata_i = 0;
      sif.amo_valid_i = 0; sif.amo_result_i = 0;

      //            op        addr          rs2           init  init_val      dly amo  exp_rd        err nrd nwr exp_mem
      vecs[0]  = '{AMO_ADD,  32'h1000, 32'h5,        1, 32'h10,       0, 0, 32'h10,       0, 1, 1, 32'h15};
      vecs[1]  = '{AMO_SWAP, 32'h1004, 32'hDEADBEEF, 1, 32'h11111111, 1, 2, 32'h11111111, 0, 1, 1, 32'hDEADBEEF};
      vecs[2]  = '{AMO_XOR,  32'h1008, 32'hFF00FF00, 1, 32'h0F0F0F0F, 0, 1, 32'h0F0F0F0F, 0, 1, 1, 32'hF00FF00F};
      vecs[3]  = '{AMO_AND,  32'h100C, 32'h0000FFFF, 1, 32'h12345678, 2, 0, 32'h12345678, 0, 1, 1, 32'h00005678};
      vecs[4]  = '{AMO_OR,   32'h1010, 32'hF0000000, 1, 32'h00000001, 0, 0, 32'h00000001, 0, 1, 1, 32'hF0000001};
      vecs[5]  = '{AMO_MIN,  32'h1014, 32'hFFFFFFFE, 1, 32'h5,        0, 0, 32'h5,        0, 1, 1, 32'hFFFFFFFE};
      vecs[6]  = '{AMO_MAXU, 32'h1018, 32'hFFFFFFFE, 1, 32'h5,        0, 0, 32'h5,        0, 1, 1, 32'hFFFFFFFE};
      vecs[7]  = '{AMO_MINU, 32'h101C, 32'h3,        1, 32'h80000000, 0, 0, 32'h80000000, 0, 1, 1, 32'h3};
      vecs[8]  = '{AMO_MAX,  32'h1020, 32'h80000000, 1, 32'h7,        0, 0, 32'h7,        0, 1, 1, 32'h7};
      vecs[9]  = '{AMO_SWAP, 32'h1002, 32'h1,        1, 32'hAB,       0, 0, 32'h0,        1, 0, 0, 32'hAB};
      vecs[10] = '{AMO_SC,   32'h3000, 32'h1,        1, 32'h55,       0, 0, 32'h1,        0, 0, 0, 32'h55};
      vecs[11] = '{AMO_LR,   32'h2000, 32'h0,        1, 32'hCAFE,     1, 0, 32'hCAFE,     0, 1, 0, 32'hCAFE};
      vecs[12] = '{AMO_SC,   32'h2000, 32'h77,       0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 32'h77};
      vecs[13] = '{AMO_SC,   32'h2000, 32'h88,       0, 32'h0,        0, 0, 32'h1,        0, 0, 0, 32'h77};
      vecs[14] = '{AMO_LR,   32'h2000, 32'h0,        0, 32'h0,        0, 0, 32'h77,       0, 1, 0, 32'h77};
      vecs[15] = '{AMO_SC,   32'h2004, 32'h9,        1, 32'h0,        0, 0, 32'h1,        0, 0, 0, 32'h0};
      vecs[16] = '{AMO_LR,   32'h2000, 32'h0,        0, 32'h0,        0, 0, 32'h77,       0, 1, 0, 32'h77};
      vecs[17] = '{AMO_LR,   32'h2001, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h77};
      vecs[18] = '{AMO_SC,   32'h2000, 32'h99,       0, 32'h0,        0, 0, 32'h1,        0, 0, 0, 32'h77};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs_or(), 32'h0);
      rst = 1'b0;

      // minimum AMO latency and a single amo_req pulse
      mem[32'h1100] = 32'h41;
      run_txn(AMO_ADD, 32'h1100, 32'h1, 0, 0, 0, 0, 40);
      check("amo_latency", r_lat, 32'd5);
      check("amo_req_pulses", r_namo, 32'd1);
      check("amo_lat_rd", r_rd, 32'h41);
      check("amo_lat_mem", mem_rd(32'h1100), 32'h42);

      // table of single transactions
      for (int i = 0; i < 19; i++) begin
         logic [31:0] wa;
         wa = {vecs[i].addr[31:2], 2'b00};
         if (vecs[i].init_en) mem[wa] = vecs[i].init_val;
         run_txn(vecs[i].op, vecs[i].addr, vecs[i].rs2, vecs[i].dly, vecs[i].dly, vecs[i].amo_dly, 0, 60);
         check($sformatf("v%0d_done", i), {31'b0, r_done}, 32'd1);
         check($sformatf("v%0d_rd", i), r_rd, vecs[i].exp_rd);
         check($sformatf("v%0d_err", i), {31'b0, r_err}, {31'b0, vecs[i].exp_err});
         check($sformatf("v%0d_nrd", i), r_nrd, vecs[i].exp_nrd);
         check($sformatf("v%0d_nwr", i), r_nwr, vecs[i].exp_nwr);
         check($sformatf("v%0d_mem", i), mem_rd(wa), vecs[i].exp_mem);
         check($sformatf("v%0d_busy1", i), {31'b0, r_busy1}, 32'd1);
         check($sformatf("v%0d_busy_at_done", i), {31'b0, r_busy_done}, 32'd0);
         check($sformatf("v%0d_bus_stable", i), {31'b0, r_stable}, 32'd1);
      end

      // snoop to the same word (different byte) kills the reservation
      txn_chk("snp_lr", AMO_LR, 32'h2000, 0, 0, 32'h77, 0);
      snoop_pulse(32'h2003);
      txn_chk("snp_sc", AMO_SC, 32'h2000, 32'h66, 0, 32'h1, 0);
      check("snp_nrd", r_nrd, 32'd0);

      // snoop to another word leaves it alone
      txn_chk("snpo_lr", AMO_LR, 32'h2000, 0, 0, 32'h77, 0);
      snoop_pulse(32'h2008);
      txn_chk("snpo_sc", AMO_SC, 32'h2000, 32'h42, 0, 32'h0, 1);
      check("snpo_mem", mem_rd(32'h2000), 32'h42);

      // snoop in the same cycle the LR sets the reservation: clear wins
      txn_chk("snps_lr", AMO_LR, 32'h2000, 0, 1, 32'h42, 0);
      txn_chk("snps_sc", AMO_SC, 32'h2000, 32'h50, 0, 32'h1, 0);

      // snoop during the SC write: write still lands, rd stays pass
      txn_chk("snpw_lr", AMO_LR, 32'h2000, 0, 0, 32'h42, 0);
      txn_chk("snpw_sc", AMO_SC, 32'h2000, 32'h43, 2, 32'h0, 1);
      check("snpw_mem", mem_rd(32'h2000), 32'h43);

      // reset while the write is pending
      mem[32'h1040] = 32'h1234;
      run_txn(AMO_SWAP, 32'h1040, 32'h5A5A, 0, 1000, 0, 0, 8);
      check("rstwr_in_wr", {30'b0, sif.bus_req_o, sif.bus_we_o}, 32'h3);
      check("rstwr_no_done", {31'b0, r_done}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rstwr_outputs", outs_or(), 32'h0);
      rst = 1'b0;
      quiet = 1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (sif.done_o || sif.busy_o || sif.bus_req_o) quiet = 0;
      end
      check("rstwr_idle_after", {31'b0, quiet}, 32'd1);
      check("rstwr_mem", mem_rd(32'h1040), 32'h1234);

      // reset drops the reservation
      txn_chk("rstr_lr", AMO_LR, 32'h2000, 0, 0, 32'h43, 0);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      txn_chk("rstr_sc", AMO_SC, 32'h2000, 32'h11, 0, 32'h1, 0);

`ifdef AMO_SEQ_TIMEOUT_EN
      // bus never acks: watchdog ends the read after TO_CYC cycles
      run_txn(AMO_LR, 32'h2000, 0, 100000, 100000, 0, 0, TO_CYC + 20);
      check("wd_done", {31'b0, r_done}, 32'd1);
      check("wd_err", {31'b0, r_err}, 32'd1);
      check("wd_rd", r_rd, 32'h0);
      check("wd_latency", r_lat, TO_CYC + 2);
      check("wd_busy_at_done", {31'b0, r_busy_done}, 32'd0);
      check("wd_bus_req_dropped", {31'b0, sif.bus_req_o}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
